// File: rtl/ripple_carry_adder_pkg.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder_pkg
//
// Purpose:
//    Shared constants for the ripple-carry adder slice. Anything that
//    instantiates the adder without overriding WIDTH gets the default
//    operand width defined here.
//
// Contents:
//    ADDER_DEFAULT_WIDTH - operand and sum width used when WIDTH is not
//                          overridden (legal widths are 1..64)
// ---------------------------------------------------------------------------
package ripple_carry_adder_pkg;

   localparam int ADDER_DEFAULT_WIDTH = 6;

endpackage : ripple_carry_adder_pkg

// File: rtl/ripple_carry_adder_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//
// Purpose:
//    A single 1-bit full adder cell. The ripple-carry adder chains these
//    explicitly, so the carry path is a gate-level ripple and never a
//    synthesised '+' operator.
//
// Ports:
//    a    in   1  operand bit A
//    b    in   1  operand bit B
//    cin  in   1  carry into this bit position
//    s    out  1  sum bit
//    cout out  1  carry out of this bit position
// ---------------------------------------------------------------------------
module full_adder
   import ripple_carry_adder_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic propagate;
   logic generate_bit;

   // Split the cell into propagate and generate terms. The carry out is
   // either generated locally or the incoming carry passed through a
   // propagating bit.
   assign propagate    = a ^ b;
   assign generate_bit = a & b;

   assign s    = propagate ^ cin;
   assign cout = generate_bit | (cin & propagate);

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder
//
// Purpose:
//    WIDTH-bit adder built as a plain chain of full_adder cells with the
//    carry-in tied to zero, followed by one register stage. It returns
//    the low WIDTH bits of a + b, the carry out of the MSB, and the
//    two's-complement overflow flag. Latency is one cycle and a new
//    operation can be accepted every cycle.
//
// Parameters:
//    WIDTH      operand/sum width in bits, 1..64
//
// Ports:
//    clk        in   1      clock, all state updates on the rising edge
//    rst        in   1      synchronous active-high reset
//    in_valid   in   1      a/b carry a valid operation this cycle
//    a          in   WIDTH  operand A
//    b          in   WIDTH  operand B
//    sum        out  WIDTH  registered (a + b) mod 2^WIDTH
//    cout       out  1      registered carry out of bit WIDTH-1
//    overflow   out  1      registered signed overflow
//    out_valid  out  1      registered copy of in_valid
// ---------------------------------------------------------------------------
module ripple_carry_adder
   import ripple_carry_adder_pkg::*;
#(
   parameter int WIDTH = ADDER_DEFAULT_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             out_valid
);

   // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB.
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_comb;
   logic             carry_comb;
   logic             ovf_comb;

   // The chain always starts with no incoming carry.
   assign carry[0] = 1'b0;

   // One full adder per bit, each feeding its carry to the next cell up.
   // The ripple structure is deliberate: no lookahead is allowed here.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (carry[i]),
         .s    (sum_comb[i]),
         .cout (carry[i+1])
      );
   end

   // Signed overflow means the carry into the MSB disagrees with the
   // carry out of it. For WIDTH=1 the carry into the MSB is the tied-off
   // zero, so overflow simply equals the carry out.
   assign carry_comb = carry[WIDTH];
   assign ovf_comb   = carry[WIDTH] ^ carry[WIDTH-1];

   // Output register stage. Reset wins over a simultaneous valid, which
   // discards that operation. Without a valid input the result registers
   // hold their last value and only out_valid drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum       <= '0;
         cout      <= 1'b0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum      <= sum_comb;
            cout     <= carry_comb;
            overflow <= ovf_comb;
         end
      end
   end

endmodule : ripple_carry_adder

// File: tb/tb_ripple_carry_adder.sv
// ---------------------------------------------------------------------------
// tb_ripple_carry_adder
//
// Purpose:
//    Self-checking bench for ripple_carry_adder. Three instances are
//    built (WIDTH = 6, 4 and 1). Expected results come from an
//    arithmetic reference model (wide a + b with sign-rule overflow) and
//    are pushed to per-instance queues when stimulus is driven, then
//    popped and compared once the registered result appears.
// ---------------------------------------------------------------------------
module tb_ripple_carry_adder;

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic       clk;
   logic       rst;

   logic       v6, v4, v1;
   logic [5:0] a6, b6, sum6;
   logic [3:0] a4, b4, sum4;
   logic [0:0] a1, b1, sum1;
   logic       cout6, ovf6, ov6;
   logic       cout4, ovf4, ov4;
   logic       cout1, ovf1, ov1;

   exp_t q6[$];
   exp_t q4[$];
   exp_t q1[$];

   int checks;
   int errors;

   ripple_carry_adder #(.WIDTH(6)) dut6 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v6),
      .a         (a6),
      .b         (b6),
      .sum       (sum6),
      .cout      (cout6),
      .overflow  (ovf6),
      .out_valid (ov6)
   );

   ripple_carry_adder #(.WIDTH(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v4),
      .a         (a4),
      .b         (b4),
      .sum       (sum4),
      .cout      (cout4),
      .overflow  (ovf4),
      .out_valid (ov4)
   );

   ripple_carry_adder #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v1),
      .a         (a1),
      .b         (b1),
      .sum       (sum1),
      .cout      (cout1),
      .overflow  (ovf1),
      .out_valid (ov1)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: a wide integer add gives sum and carry; overflow
   // uses the sign rule (equal operand signs, different result sign).
   function automatic exp_t ref_add(input int w, input logic [63:0] x, input logic [63:0] y);
      logic [64:0] full;
      logic [63:0] mask;
      exp_t        r;
      mask   = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      full   = {1'b0, x & mask} + {1'b0, y & mask};
      r.sum  = full[63:0] & mask;
      r.cout = full[w];
      r.ovf  = (x[w-1] == y[w-1]) && (r.sum[w-1] != x[w-1]);
      return r;
   endfunction

   // Reset with all inputs idle; every instance must come up cleared.
   task automatic test_reset();
      rst = 1'b1;
      v6 = 1'b0; v4 = 1'b0; v1 = 1'b0;
      a6 = '0; b6 = '0; a4 = '0; b4 = '0; a1 = '0; b1 = '0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({sum6, cout6, ovf6} !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_w6_result got=%b exp=0", {sum6, cout6, ovf6});
      end
      checks++;
      if (ov6 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_w6_out_valid got=%b exp=0", ov6);
      end
      checks++;
      if ({sum4, cout4, ovf4, ov4} !== 7'd0) begin
         errors++;
         $display("[TB] FAIL reset_w4 got=%b exp=0", {sum4, cout4, ovf4, ov4});
      end
      checks++;
      if ({sum1, cout1, ovf1, ov1} !== 4'd0) begin
         errors++;
         $display("[TB] FAIL reset_w1 got=%b exp=0", {sum1, cout1, ovf1, ov1});
      end
      rst = 1'b0;
   endtask

   // Single isolated operations covering ordinary, wrap and overflow cases.
   task automatic test_basic();
      int   va[4] = '{3, 63, 31, 0};
      int   vb[4] = '{35, 1, 1, 0};
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         v6 = 1'b1;
         a6 = 6'(va[i]);
         b6 = 6'(vb[i]);
         q6.push_back(ref_add(6, 64'(a6), 64'(b6)));
         @(negedge clk);
         v6 = 1'b0;
         e = q6.pop_front();
         checks++;
         if (sum6 !== e.sum[5:0]) begin
            errors++;
            $display("[TB] FAIL basic_sum a=%0d b=%0d got=%0d exp=%0d", va[i], vb[i], sum6, e.sum[5:0]);
         end
         checks++;
         if (cout6 !== e.cout) begin
            errors++;
            $display("[TB] FAIL basic_cout a=%0d b=%0d got=%b exp=%b", va[i], vb[i], cout6, e.cout);
         end
         checks++;
         if (ovf6 !== e.ovf) begin
            errors++;
            $display("[TB] FAIL basic_overflow a=%0d b=%0d got=%b exp=%b", va[i], vb[i], ovf6, e.ovf);
         end
         checks++;
         if (ov6 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_out_valid a=%0d b=%0d got=%b exp=1", va[i], vb[i], ov6);
         end
         @(negedge clk);
      end
   endtask

   // Three operations on consecutive cycles, then an idle cycle where the
   // last result must be held and out_valid must drop.
   task automatic test_back_to_back();
      int   va[3] = '{10, 63, 5};
      int   vb[3] = '{20, 63, 0};
      exp_t e;
      exp_t last;
      last = '{64'd0, 1'b0, 1'b0};
      for (int i = 0; i < 3; i++) begin
         v6 = 1'b1;
         a6 = 6'(va[i]);
         b6 = 6'(vb[i]);
         q6.push_back(ref_add(6, 64'(a6), 64'(b6)));
         @(negedge clk);
         e    = q6.pop_front();
         last = e;
         checks++;
         if ({sum6, cout6, ovf6} !== {e.sum[5:0], e.cout, e.ovf}) begin
            errors++;
            $display("[TB] FAIL b2b_result op=%0d got=%0d/%b/%b exp=%0d/%b/%b",
                     i, sum6, cout6, ovf6, e.sum[5:0], e.cout, e.ovf);
         end
         checks++;
         if (ov6 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_out_valid op=%0d got=%b exp=1", i, ov6);
         end
      end
      v6 = 1'b0;
      @(negedge clk);
      checks++;
      if (ov6 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_idle_out_valid got=%b exp=0", ov6);
      end
      checks++;
      if ({sum6, cout6, ovf6} !== {last.sum[5:0], last.cout, last.ovf}) begin
         errors++;
         $display("[TB] FAIL b2b_hold got=%0d/%b/%b exp=%0d/%b/%b",
                  sum6, cout6, ovf6, last.sum[5:0], last.cout, last.ovf);
      end
   endtask

   // Reset asserted alongside a valid operation: the operation is lost
   // and the outputs clear. The same operation afterwards goes through.
   task automatic test_reset_priority();
      exp_t e;
      rst = 1'b1;
      v6  = 1'b1;
      a6  = 6'd12;
      b6  = 6'd7;
      @(negedge clk);
      checks++;
      if ({sum6, cout6, ovf6, ov6} !== 9'd0) begin
         errors++;
         $display("[TB] FAIL rst_priority got=%b exp=0", {sum6, cout6, ovf6, ov6});
      end
      rst = 1'b0;
      q6.push_back(ref_add(6, 64'(a6), 64'(b6)));
      @(negedge clk);
      v6 = 1'b0;
      e  = q6.pop_front();
      checks++;
      if (sum6 !== e.sum[5:0] || ov6 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rst_recover got=%0d/%b exp=%0d/1", sum6, ov6, e.sum[5:0]);
      end
   endtask

   // Every operand pair for the 4-bit and 1-bit instances, fully pipelined.
   task automatic test_exhaustive();
      exp_t e;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            v4 = 1'b1;
            a4 = 4'(x);
            b4 = 4'(y);
            q4.push_back(ref_add(4, 64'(a4), 64'(b4)));
            @(negedge clk);
            e = q4.pop_front();
            checks++;
            if ({sum4, cout4, ovf4, ov4} !== {e.sum[3:0], e.cout, e.ovf, 1'b1}) begin
               errors++;
               $display("[TB] FAIL w4_sweep a=%0d b=%0d got=%0d/%b/%b/%b exp=%0d/%b/%b/1",
                        x, y, sum4, cout4, ovf4, ov4, e.sum[3:0], e.cout, e.ovf);
            end
         end
      end
      v4 = 1'b0;
      for (int x = 0; x < 2; x++) begin
         for (int y = 0; y < 2; y++) begin
            v1 = 1'b1;
            a1 = 1'(x);
            b1 = 1'(y);
            q1.push_back(ref_add(1, 64'(a1), 64'(b1)));
            @(negedge clk);
            e = q1.pop_front();
            checks++;
            if ({sum1, cout1, ovf1, ov1} !== {e.sum[0], e.cout, e.ovf, 1'b1}) begin
               errors++;
               $display("[TB] FAIL w1_sweep a=%0d b=%0d got=%b/%b/%b/%b exp=%b/%b/%b/1",
                        x, y, sum1, cout1, ovf1, ov1, e.sum[0], e.cout, e.ovf);
            end
         end
      end
      v1 = 1'b0;
   endtask

   // Random operands with random idle gaps; idle cycles must hold the
   // last result while out_valid follows in_valid.
   task automatic test_random_gaps();
      exp_t held;
      logic vld;
      rst = 1'b1;
      v6  = 1'b0;
      @(negedge clk);
      rst  = 1'b0;
      held = '{64'd0, 1'b0, 1'b0};
      for (int n = 0; n < 300; n++) begin
         vld = ($urandom_range(0, 3) != 0);
         v6  = vld;
         a6  = 6'($urandom);
         b6  = 6'($urandom);
         if (vld) q6.push_back(ref_add(6, 64'(a6), 64'(b6)));
         @(negedge clk);
         if (vld) held = q6.pop_front();
         checks++;
         if ({sum6, cout6, ovf6, ov6} !== {held.sum[5:0], held.cout, held.ovf, vld}) begin
            errors++;
            $display("[TB] FAIL random cycle=%0d got=%0d/%b/%b/%b exp=%0d/%b/%b/%b",
                     n, sum6, cout6, ovf6, ov6, held.sum[5:0], held.cout, held.ovf, vld);
         end
      end
      v6 = 1'b0;
      checks++;
      if (q6.size() + q4.size() + q1.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain got=%0d exp=0", q6.size() + q4.size() + q1.size());
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_reset_priority();
      test_exhaustive();
      test_random_gaps();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_ripple_carry_adder
